uart_hex_cmd_parser: RTL and testbench
======================================

UART_HEX_CMD_PARSER -- requirements
Module: uart_hex_cmd_parser

Interface
REQ-001 The block SHALL have one parameter, TIMEOUT_CYCLES, default 2500000, giving the inter-byte timeout in clocks (100 ms at 25 MHz).
REQ-002 The block SHALL have port i_clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_rx_byte, input, 8 bits: received UART byte, valid only when i_rx_valid=1.
REQ-005 The block SHALL have port i_rx_valid, input, 1 bit: single-cycle strobe qualifying i_rx_byte.
REQ-006 The block SHALL have port o_cmd_byte, output, 8 bits: last committed command value, held between commits.
REQ-007 The block SHALL have port o_cmd_valid, output, 1 bit: one-cycle pulse on each commit.
REQ-008 The block SHALL have port o_err, output, 1 bit: one-cycle pulse on each protocol error or timeout.
REQ-009 The block SHALL have port o_busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-010 Command format SHALL be 'P' or 'p', then two ASCII hex digits (high nibble first), then CR (0x0D) or LF (0x0A).
REQ-011 Hex digits SHALL be 0-9, A-F and a-f; every other byte is non-hex.
REQ-012 The state machine SHALL have exactly five states: IDLE, HI, LO, TERM, ERR.
REQ-013 In IDLE, a valid 'P'/'p' SHALL go to HI; valid CR, LF or space (0x20) SHALL leave the state in IDLE; any other valid byte SHALL go to ERR.
REQ-014 In HI, a valid hex digit SHALL store the high nibble and go to LO; any non-hex byte SHALL go to ERR.
REQ-015 In LO, a valid hex digit SHALL store the low nibble and go to TERM; any non-hex byte SHALL go to ERR.
REQ-016 In TERM, a valid CR or LF SHALL commit the byte and go to IDLE; any other valid byte SHALL go to ERR.
REQ-017 In ERR, a valid CR or LF SHALL return to IDLE without a commit; all other bytes SHALL be discarded.
REQ-018 On commit, o_cmd_byte SHALL update and o_cmd_valid SHALL be 1 on the first rising edge after the terminator's valid cycle (latency 1), for exactly one cycle.
REQ-019 o_err SHALL pulse for one cycle on the edge where the state enters ERR; it SHALL NOT pulse again while the state remains in ERR.
REQ-020 The timeout counter SHALL clear on every i_rx_valid and on every state change, and SHALL increment each cycle in HI, LO, TERM and ERR.
REQ-021 When the counter reaches TIMEOUT_CYCLES-1 in HI, LO or TERM, the state SHALL go to IDLE with one o_err pulse and no commit.
REQ-022 When the counter reaches TIMEOUT_CYCLES-1 in ERR, the state SHALL go to IDLE with no additional o_err pulse.
REQ-023 If i_rx_valid and timeout expiry occur in the same cycle, the byte SHALL be processed and the timeout ignored.
REQ-024 The counter width SHALL be clog2(TIMEOUT_CYCLES) and SHALL never wrap.
REQ-025 o_cmd_byte SHALL change only on commit; a partially entered command SHALL never alter it.
REQ-026 o_busy SHALL be a registered-state decode with no combinational path from i_rx_valid.
REQ-027 The block SHALL accept back-to-back i_rx_valid strobes on consecutive cycles without loss.

Reset
REQ-028 While i_rst_n=0, the block SHALL force the state to IDLE, the nibble registers and counter to 0, o_cmd_byte=0x00, and o_cmd_valid, o_err and o_busy to 0.
REQ-029 A reset asserted mid-command SHALL discard the partial command; bytes received after release SHALL be parsed from IDLE.

Verification
REQ-030 Sending 'P','3','A',0x0D SHALL give o_cmd_byte=0x3A and o_cmd_valid high for one cycle, one clock after the 0x0D strobe; o_busy SHALL then be 0.
REQ-031 Sending 'p','f','F',0x0A on consecutive cycles SHALL give o_cmd_byte=0xFF with one o_cmd_valid pulse.
REQ-032 Sending 'P','G' SHALL give one o_err pulse after 'G' with o_cmd_byte unchanged; then 'Z',0x0D SHALL give no further pulse; then 'P','0','5',0x0D SHALL give 0x05.
REQ-033 With TIMEOUT_CYCLES=16, sending 'P','1' then idling SHALL give one o_err pulse 16 clocks after '1', o_busy=0, and o_cmd_byte unchanged.
REQ-034 Sending 'P','7', pulsing i_rst_n low for 1 cycle, then sending 0x0D SHALL give all outputs 0 with no o_cmd_valid and no o_err.
REQ-035 Sending 'P','1','2','X' SHALL give an o_err pulse after 'X' and no commit; o_busy SHALL stay 1 until the next 0x0D.

Source files
------------

// File: rtl/uart_hex_cmd_parser.sv
// ASCII hex command parser: accepts "P<hi><lo><CR|LF>" from a UART byte stream
// and emits the decoded command byte, with protocol-error and inter-byte timeout handling.
module uart_hex_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_valid,
    output logic [7:0] o_cmd_byte,
    output logic       o_cmd_valid,
    output logic       o_err,
    output logic       o_busy
);

    localparam int unsigned       CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_P_UC  = 8'h50;
    localparam logic [7:0] CH_P_LC  = 8'h70;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_TERM,
        ST_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       hi_nib_q, hi_nib_d;
    logic [3:0]       lo_nib_q, lo_nib_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_byte_q, cmd_byte_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             err_q, err_d;
    logic             timeout;

    function automatic logic is_hex(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) ||
               ((b >= 8'h41) && (b <= 8'h46)) ||
               ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    // Letters A-F and a-f share the low nibble 1..6, so both map by adding 9.
    function automatic logic [3:0] hex_val(input logic [7:0] b);
        if (b <= 8'h39) begin
            return b[3:0];
        end
        return b[3:0] + 4'd9;
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == CH_CR) || (b == CH_LF);
    endfunction

    assign timeout = (state_q != ST_IDLE) && (cnt_q == CNT_MAX);

    // NOTE: every signal driven here gets a default first, so no path can leave
    // a variable unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        hi_nib_d    = hi_nib_q;
        lo_nib_d    = lo_nib_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        err_d       = 1'b0;
        cnt_d       = cnt_q;

        if (i_rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if ((i_rx_byte == CH_P_UC) || (i_rx_byte == CH_P_LC)) begin
                        state_d = ST_HI;
                    end else if (!is_eol(i_rx_byte) && (i_rx_byte != CH_SPACE)) begin
                        state_d = ST_ERR;
                    end
                end
                ST_HI: begin
                    if (is_hex(i_rx_byte)) begin
                        hi_nib_d = hex_val(i_rx_byte);
                        state_d  = ST_LO;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                ST_LO: begin
                    if (is_hex(i_rx_byte)) begin
                        lo_nib_d = hex_val(i_rx_byte);
                        state_d  = ST_TERM;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                ST_TERM: begin
                    if (is_eol(i_rx_byte)) begin
                        cmd_byte_d  = {hi_nib_q, lo_nib_q};
                        cmd_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                ST_ERR: begin
                    if (is_eol(i_rx_byte)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            // An abandoned command is reported; leaving ERR was already reported on entry.
            state_d = ST_IDLE;
            err_d   = (state_q != ST_ERR);
        end

        if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
            err_d = 1'b1;
        end

        if (i_rx_valid || (state_d != state_q) || (state_q == ST_IDLE)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            hi_nib_q    <= '0;
            lo_nib_q    <= '0;
            cnt_q       <= '0;
            cmd_byte_q  <= '0;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_nib_q    <= hi_nib_d;
            lo_nib_q    <= lo_nib_d;
            cnt_q       <= cnt_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= err_d;
        end
    end

    assign o_cmd_byte  = cmd_byte_q;
    assign o_cmd_valid = cmd_valid_q;
    assign o_err       = err_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_hex_cmd_parser.sv
// Self-checking bench for uart_hex_cmd_parser: a table of byte strobes with
// expected outputs, plus directed timeout and reset sequences.
module tb_uart_hex_cmd_parser;

    localparam int unsigned TO = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] cmd_byte;
    logic       cmd_valid;
    logic       err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       vld;
        logic [7:0] rx;
        logic       exp_valid;
        logic       exp_err;
        logic       exp_busy;
        logic [7:0] exp_cmd;
    } vec_t;

    vec_t vecs[$];

    uart_hex_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_byte  (rx_byte),
        .i_rx_valid (rx_valid),
        .o_cmd_byte (cmd_byte),
        .o_cmd_valid(cmd_valid),
        .o_err      (err),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic add(input logic vld, input logic [7:0] rx, input logic v,
                       input logic e, input logic b, input logic [7:0] c);
        vec_t t;
        t.vld = vld; t.rx = rx; t.exp_valid = v; t.exp_err = e; t.exp_busy = b; t.exp_cmd = c;
        vecs.push_back(t);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int err_seen;
        int err_at;
        int idle_at;

        rst_n    = 1'b0;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;

        // vld, byte, exp_valid, exp_err, exp_busy, exp_cmd
        add(1, 8'h50, 0, 0, 1, 8'h00); // P 3 A CR
        add(1, 8'h33, 0, 0, 1, 8'h00);
        add(1, 8'h41, 0, 0, 1, 8'h00);
        add(1, 8'h0D, 1, 0, 0, 8'h3A);
        add(0, 8'h00, 0, 0, 0, 8'h3A);
        add(1, 8'h70, 0, 0, 1, 8'h3A); // p f F LF
        add(1, 8'h66, 0, 0, 1, 8'h3A);
        add(1, 8'h46, 0, 0, 1, 8'h3A);
        add(1, 8'h0A, 1, 0, 0, 8'hFF);
        add(1, 8'h50, 0, 0, 1, 8'hFF); // P G -> err, Z no re-pulse, CR back to idle
        add(1, 8'h47, 0, 1, 1, 8'hFF);
        add(1, 8'h5A, 0, 0, 1, 8'hFF);
        add(1, 8'h0D, 0, 0, 0, 8'hFF);
        add(1, 8'h50, 0, 0, 1, 8'hFF); // P 0 5 CR
        add(1, 8'h30, 0, 0, 1, 8'hFF);
        add(1, 8'h35, 0, 0, 1, 8'hFF);
        add(1, 8'h0D, 1, 0, 0, 8'h05);
        add(1, 8'h20, 0, 0, 0, 8'h05); // space / CR ignored in idle
        add(1, 8'h0D, 0, 0, 0, 8'h05);
        add(1, 8'h51, 0, 1, 1, 8'h05); // stray byte in idle
        add(1, 8'h0A, 0, 0, 0, 8'h05);
        add(1, 8'h50, 0, 0, 1, 8'h05); // P 1 2 X: error at terminator
        add(1, 8'h31, 0, 0, 1, 8'h05);
        add(1, 8'h32, 0, 0, 1, 8'h05);
        add(1, 8'h58, 0, 1, 1, 8'h05);
        add(1, 8'h33, 0, 0, 1, 8'h05);
        add(1, 8'h0D, 0, 0, 0, 8'h05);
        add(1, 8'h50, 0, 0, 1, 8'h05); // P a B <gap> LF
        add(1, 8'h61, 0, 0, 1, 8'h05);
        add(1, 8'h42, 0, 0, 1, 8'h05);
        add(0, 8'h00, 0, 0, 1, 8'h05);
        add(1, 8'h0A, 1, 0, 0, 8'hAB);
        add(1, 8'h50, 0, 0, 1, 8'hAB); // P 9 P: non-hex in low nibble
        add(1, 8'h39, 0, 0, 1, 8'hAB);
        add(1, 8'h50, 0, 1, 1, 8'hAB);
        add(1, 8'h0D, 0, 0, 0, 8'hAB);

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", cmd_byte, 8'h00);
        check("rst_valid", {7'd0, cmd_valid}, 8'h00);
        check("rst_err", {7'd0, err}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].vld) begin
                send(vecs[i].rx);
            end else begin
                idle_cycle();
            end
            check($sformatf("v%0d_valid", i), {7'd0, cmd_valid}, {7'd0, vecs[i].exp_valid});
            check($sformatf("v%0d_err", i), {7'd0, err}, {7'd0, vecs[i].exp_err});
            check($sformatf("v%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].exp_busy});
            check($sformatf("v%0d_cmd", i), cmd_byte, vecs[i].exp_cmd);
        end

        // Timeout in LO: error pulse TO clocks after the '1' edge.
        send(8'h50);
        send(8'h31);
        err_at = -1;
        for (int k = 1; k <= 40; k++) begin
            idle_cycle();
            if (err) begin
                err_at = k;
                break;
            end
        end
        check("to_err_delay", 8'(err_at), 8'(TO));
        check("to_busy", {7'd0, busy}, 8'h00);
        check("to_cmd", cmd_byte, 8'hAB);
        idle_cycle();
        check("to_err_single", {7'd0, err}, 8'h00);

        // Byte arriving on the expiry cycle wins over the timeout.
        send(8'h50);
        send(8'h31);
        err_seen = 0;
        for (int k = 1; k < TO; k++) begin
            idle_cycle();
            if (err) err_seen++;
        end
        send(8'h32);
        if (err) err_seen++;
        check("race_no_err", 8'(err_seen), 8'h00);
        check("race_busy", {7'd0, busy}, 8'h01);
        send(8'h0D);
        check("race_valid", {7'd0, cmd_valid}, 8'h01);
        check("race_cmd", cmd_byte, 8'h12);

        // Timeout out of ERR: back to idle with no further error pulse.
        send(8'h5A);
        check("errto_enter", {7'd0, err}, 8'h01);
        err_seen = 0;
        idle_at  = -1;
        for (int k = 1; k <= 24; k++) begin
            idle_cycle();
            if (err) err_seen++;
            if (!busy && idle_at < 0) idle_at = k;
        end
        check("errto_no_err", 8'(err_seen), 8'h00);
        check("errto_idle_at", 8'(idle_at), 8'(TO));

        // Reset mid-command discards the partial command.
        send(8'h50);
        send(8'h37);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd", cmd_byte, 8'h00);
        check("midrst_busy", {7'd0, busy}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h0D);
        check("post_rst_cmd", cmd_byte, 8'h00);
        check("post_rst_valid", {7'd0, cmd_valid}, 8'h00);
        check("post_rst_err", {7'd0, err}, 8'h00);
        check("post_rst_busy", {7'd0, busy}, 8'h00);
        idle_cycle();
        check("post_rst_valid2", {7'd0, cmd_valid}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
